// File: rtl/btb_predictor_pkg.sv
// Shared branch-prediction definitions: BTB direction-state encoding and the
// opcode/branch constants used by the branch-resolution unit.
package btb_predictor_pkg;

  // 2-bit direction state; bit 1 set means predict taken.
  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] STRONG_TAKEN     = 2'b10;
  localparam logic [1:0] WEAK_TAKEN       = 2'b11;

  // Control-flow opcodes seen by branch resolution (RV32I major opcodes).
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Branch funct3 codes.
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // True when a direction state predicts taken.
  function automatic logic state_predicts_taken(input logic [1:0] state);
    return state[1];
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational next-state for the BTB 2-bit saturating direction counter.
// Taken walks SNT->WNT->WT->ST; not-taken walks ST->WT->WNT->SNT.
module btb_sat_counter
  import btb_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       act_taken,
  output logic [1:0] state_next
);

  // Step one position toward the resolved direction, saturating at the ends.
  always_comb begin
    state_next = state;
    unique case (state)
      STRONG_NOT_TAKEN: state_next = act_taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   state_next = act_taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       state_next = act_taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
      STRONG_TAKEN:     state_next = act_taken ? STRONG_TAKEN   : WEAK_TAKEN;
      default:          state_next = state;
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction state.
// IF-stage lookup is combinational; EX-stage resolution updates the table on clk.
// Optional macro BTB_WR_BYPASS_EN: same-cycle update to the looked-up entry is
// forwarded to the lookup instead of becoming visible one cycle later.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_tgt,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_modify_pc,
  input  logic        ex_pred_taken
);

  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [31:0]      tgt_q   [DEPTH];
  logic [1:0]       state_q [DEPTH];

  logic [IDX_W-1:0] ex_idx, if_idx;
  logic [TAG_W-1:0] ex_tag, if_tag;
  logic             ex_hit, act_taken, wr_en;
  logic [1:0]       sat_next, wr_state;
  logic [31:0]      wr_tgt;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_tgt;
  logic [1:0]       rd_state;
  logic             unused_pc_lsbs;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  btb_sat_counter u_sat_counter (
    .state      (state_q[ex_idx]),
    .act_taken  (act_taken),
    .state_next (sat_next)
  );

  // Resolve the update: hits train the counter, taken misses allocate at WT.
  always_comb begin
    act_taken = ex_modify_pc ^ ex_pred_taken;
    ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    // Reset discards any in-flight update.
    wr_en     = ex_update && !rst && (ex_hit || act_taken);
    wr_state  = ex_hit ? sat_next : WEAK_TAKEN;
    wr_tgt    = act_taken ? ex_target : tgt_q[ex_idx];
  end

  // Valid vector: the only table state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[ex_idx] <= 1'b1;
    end
  end

  // Entry payload arrays; written only by a qualified update.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[ex_idx]   <= ex_tag;
      tgt_q[ex_idx]   <= wr_tgt;
      state_q[ex_idx] <= wr_state;
    end
  end

  // Lookup mux, with optional forwarding of a same-cycle write to the same entry.
  always_comb begin
    rd_valid = valid_q[if_idx];
    rd_tag   = tag_q[if_idx];
    rd_tgt   = tgt_q[if_idx];
    rd_state = state_q[if_idx];
`ifdef BTB_WR_BYPASS_EN
    if (wr_en && (ex_idx == if_idx) && (ex_tag == if_tag)) begin
      rd_valid = 1'b1;
      rd_tag   = ex_tag;
      rd_tgt   = wr_tgt;
      rd_state = wr_state;
    end
`endif
    if_pred_taken = !rst && rd_valid && (rd_tag == if_tag) && state_predicts_taken(rd_state);
    if_pred_tgt   = if_pred_taken ? rd_tgt : 32'h0;
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: each checked cycle pushes the expected
// {taken, target} pair; a negedge monitor pops and compares it.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_tgt;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_modify_pc;
  logic        ex_pred_taken;

  int          total = 0;
  int          bad   = 0;
  int          n_lk  = 0;
  bit          chk_en = 1'b0;
  logic [32:0] sb [$];

`ifdef BTB_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  btb_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .if_pred_tgt   (if_pred_tgt),
    .ex_update     (ex_update),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_modify_pc  (ex_modify_pc),
    .ex_pred_taken (ex_pred_taken)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare combinational outputs mid-cycle, away from the update edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check_eq($sformatf("lk%0d_taken", n_lk), {63'd0, if_pred_taken}, {63'd0, e[32]});
        check_eq($sformatf("lk%0d_tgt", n_lk), {32'd0, if_pred_tgt}, {32'd0, e[31:0]});
      end
      n_lk++;
    end
  end

  // One clock cycle of stimulus, optionally with an expected lookup result.
  task automatic cyc(input logic r, input logic up, input logic [31:0] epc,
                     input logic [31:0] etgt, input logic mod, input logic pred,
                     input logic [31:0] ipc, input bit chk, input logic et,
                     input logic [31:0] etg);
    rst           = r;
    ex_update     = up;
    ex_pc         = epc;
    ex_target     = etgt;
    ex_modify_pc  = mod;
    ex_pred_taken = pred;
    if_pc         = ipc;
    chk_en        = chk;
    if (chk) sb.push_back({et, etg});
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic et, input logic [31:0] etg);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, pc, 1'b1, et, etg);
  endtask

  // act_taken = mod ^ pred
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic mod,
                     input logic pred);
    cyc(1'b0, 1'b1, pc, tgt, mod, pred, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; ex_update = 1'b0; ex_pc = '0; ex_target = '0;
    ex_modify_pc = 1'b0; ex_pred_taken = 1'b0; if_pc = '0;
    @(posedge clk); #1;
    // Outputs held low in reset; an update during reset is ignored.
    cyc(1'b1, 1'b1, 32'h100, 32'h900, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h0);

    // Taken miss allocates at WT; same-cycle visibility depends on bypass.
    cyc(1'b0, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h100, 1'b1, BYPASS,
        BYPASS ? 32'h200 : 32'h0);
    look(32'h100, 1'b1, 32'h200);

    // WT -> ST -> ST -> ST, then back down.
    upd(32'h100, 32'h200, 1'b0, 1'b1);
    upd(32'h100, 32'h200, 1'b0, 1'b1);
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    look(32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h0, 1'b1, 1'b1);   // ST -> WT
    look(32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h0, 1'b0, 1'b0);   // WT -> WNT
    look(32'h100, 1'b0, 32'h0);
    upd(32'h100, 32'h0, 1'b1, 1'b1);   // WNT -> SNT
    upd(32'h100, 32'h0, 1'b1, 1'b1);   // SNT saturates
    upd(32'h100, 32'h208, 1'b1, 1'b0); // SNT -> WNT
    look(32'h100, 1'b0, 32'h0);
    upd(32'h100, 32'h20c, 1'b1, 1'b0); // WNT -> WT, new target
    look(32'h100, 1'b1, 32'h20c);
    look(32'h103, 1'b1, 32'h20c);      // pc[1:0] ignored

    // Not-taken miss writes nothing.
    upd(32'h140, 32'h777, 1'b0, 1'b0);
    look(32'h140, 1'b0, 32'h0);

    // Alias at index 0 with a different tag.
    upd(32'h200, 32'h300, 1'b1, 1'b0);
    look(32'h100, 1'b0, 32'h0);
    look(32'h200, 1'b1, 32'h300);
    upd(32'h100, 32'h0, 1'b0, 1'b0);   // not-taken miss must not evict
    look(32'h200, 1'b1, 32'h300);

    // Same-cycle update and lookup at an empty index.
    cyc(1'b0, 1'b1, 32'h140, 32'h400, 1'b1, 1'b0, 32'h140, 1'b1, BYPASS,
        BYPASS ? 32'h400 : 32'h0);
    look(32'h140, 1'b1, 32'h400);
    // Same index, different tag: never forwarded.
    cyc(1'b0, 1'b1, 32'h180, 32'h600, 1'b1, 1'b0, 32'h280, 1'b1, 1'b0, 32'h0);
    look(32'h180, 1'b1, 32'h600);

    // Reset with a concurrent taken update clears everything and drops the write.
    cyc(1'b1, 1'b1, 32'h1c0, 32'h500, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h0);
    look(32'h180, 1'b0, 32'h0);
    look(32'h140, 1'b0, 32'h0);
    look(32'h1c0, 1'b0, 32'h0);
    look(32'h200, 1'b0, 32'h0);

    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
